// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the signed-divide overflow detector.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  // True when a / b is the one signed quotient that does not fit: -2^(w-1) / -1.
  function automatic logic div_overflow(input logic [63:0] a, input logic [63:0] b,
                                        input int unsigned width);
    logic [63:0] mask;
    logic [63:0] min_neg;
    mask    = {64{1'b1}} >> (64 - width);
    min_neg = 64'd1 << (width - 1);
    return ((a & mask) == min_neg) && ((b & mask) == mask);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// E-stage to MDU signal bundle; the pipeline drives master, the MDU is slave.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             req;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] out;

  modport master (output start, req, op, a, b, input busy, out);
  modport slave  (input start, req, op, a, b, output busy, out);
endinterface

// File: rtl/mdu.sv
// The multiply/divide unit top level is mdu_iter (rtl/mdu_iter.sv); this file declares nothing.

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider on operand magnitudes: WIDTH iterations after go,
// then done is held for one cycle with sign-fixed quotient/remainder on quo/rem.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};

    if (go) begin
      active_d = 1'b1;
      cnt_d    = CW'(WIDTH);
      rem_d    = '0;
      quo_d    = a_neg ? -a : a;
      dvs_d    = b_neg ? -b : b;
      a_d      = a;
      negq_d   = a_neg ^ b_neg;
      negr_d   = a_neg;
      zero_d   = (b == '0);
      ovf_d    = is_signed & div_overflow(64'(a), 64'(b), WIDTH);
    end else if (active_q) begin
      if (cnt_q != '0) begin
        // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_comb begin
    done = active_q & (cnt_q == '0);
    if (zero_q) begin
      quo = '1;
      rem = a_q;
    end else if (ovf_q) begin
      quo = a_q;
      rem = '0;
    end else begin
      quo = negq_q ? -quo_q : quo_q;
      rem = negr_q ? -rem_q : rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit holding HI/LO: multi-cycle mult/madd/msub family with a
// pending result register, and an iterative divider sub-module.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept, mul_op, div_op, op_signed, op_acc, op_sub;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
  logic               div_go, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  always_comb begin
    mul_op    = 1'b0;
    div_op    = 1'b0;
    op_signed = 1'b0;
    op_acc    = 1'b0;
    op_sub    = 1'b0;
    case (bus.op)
      OP_MULT:  begin mul_op = 1'b1; op_signed = 1'b1; end
      OP_MULTU: mul_op = 1'b1;
      OP_DIV:   begin div_op = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  div_op = 1'b1;
      OP_MADD:  begin mul_op = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      OP_MADDU: begin mul_op = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin mul_op = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      OP_MSUBU: begin mul_op = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      default:  ;
    endcase

    accept = bus.start & ~bus.req & ~busy_q;
    div_go = accept & div_op;
    // sign-extending to 2*WIDTH makes the truncated unsigned product the signed one
    ext_a  = op_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    ext_b  = op_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    prod   = ext_a * ext_b;
    acc    = {hi_q, lo_q};
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && mul_op) begin
          state_d = ST_MUL;
          busy_d  = 1'b1;
          cnt_d   = CW'(MUL_LAT - 1);
          pend_d  = op_acc ? (op_sub ? acc - prod : acc + prod) : prod;
        end else if (div_go) begin
          state_d = ST_DIV;
          busy_d  = 1'b1;
        end else if (!bus.start && !bus.req) begin
          if (bus.op == OP_MTHI) hi_d = bus.a;
          if (bus.op == OP_MTLO) lo_d = bus.a;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = pend_q;
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        if (div_done) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  mdu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .is_signed(op_signed),
    .a        (bus.a),
    .b        (bus.b),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    case (bus.op)
      OP_MFHI: bus.out = hi_q;
      OP_MFLO: bus.out = lo_q;
      default: bus.out = '0;
    endcase
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter at WIDTH=32/MUL_LAT=5 and WIDTH=16/MUL_LAT=1.
module tb_mdu_iter;
  import mdu_pkg::*;

  typedef struct {
    logic [63:0] hilo;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus0 ();
  mdu_iter_if #(.WIDTH(16)) bus1 ();

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  mdu_iter #(.WIDTH(16), .MUL_LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  a_nostart0: assert property (@(posedge clk) disable iff (rst0) !(bus0.start && bus0.busy));
  a_nostart1: assert property (@(posedge clk) disable iff (rst1) !(bus1.start && bus1.busy));

  exp_t        sb0[$];
  exp_t        sb1[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi, m_lo;

  function automatic logic [63:0] model32(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic [63:0] acc, p;
    int sa, sbv, q, r;
    acc = {hi, lo};
    if (op == OP_MULT || op == OP_MADD || op == OP_MSUB)
      p = longint'($signed(a)) * longint'($signed(b));
    else
      p = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MULT, OP_MULTU: return p;
      OP_MADD, OP_MADDU: return acc + p;
      OP_MSUB, OP_MSUBU: return acc - p;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
        sa = a; sbv = b;
        q = sa / sbv; r = sa % sbv;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.start = 1'b0; bus0.req = 1'b0; bus0.op = 4'd12; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.req = 1'b0; bus1.op = 4'd12; bus1.a = '0; bus1.b = '0;
  endtask

  task automatic read0(output logic [31:0] hi, output logic [31:0] lo);
    bus0.op = OP_MFHI; #1 hi = bus0.out;
    bus0.op = OP_MFLO; #1 lo = bus0.out;
    bus0.op = 4'd12;
  endtask

  task automatic read1(output logic [15:0] hi, output logic [15:0] lo);
    bus1.op = OP_MFHI; #1 hi = bus1.out;
    bus1.op = OP_MFLO; #1 lo = bus1.out;
    bus1.op = 4'd12;
  endtask

  task automatic mt0(input logic [3:0] op, input logic [31:0] v);
    bus0.op = op; bus0.a = v;
    tick();
    bus0.op = 4'd12;
    if (op == OP_MTHI) m_hi = v; else m_lo = v;
  endtask

  // Issue one start, push the model result, then wait for busy to fall (bounded).
  task automatic run0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic hold_req, output int unsigned cyc, output logic [31:0] last,
                      output logic [31:0] hi, output logic [31:0] lo, output exp_t e,
                      output logic [31:0] old_hi);
    exp_t pushed;
    old_hi = m_hi;
    pushed.hilo = model32(op, a, b, m_hi, m_lo);
    pushed.lat  = (op == OP_DIV || op == OP_DIVU) ? 33 : 5;
    sb0.push_back(pushed);
    bus0.start = 1'b1; bus0.op = op; bus0.a = a; bus0.b = b;
    tick();
    bus0.start = 1'b0; bus0.op = OP_MFHI; bus0.req = hold_req;
    cyc = 0; last = 'x;
    while (bus0.busy === 1'b1 && cyc < 200) begin
      last = bus0.out;
      cyc++;
      tick();
    end
    bus0.req = 1'b0;
    read0(hi, lo);
    e = sb0.pop_front();
    {m_hi, m_lo} = e.hilo;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    logic [15:0] h16, l16;
    rst0 = 1'b1; rst1 = 1'b1;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    m_hi = '0; m_lo = '0;
    n_checks++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy0 got %b want 0", bus0.busy); else n_pass++;
    n_checks++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy1 got %b want 0", bus1.busy); else n_pass++;
    n_checks++; if (bus0.out !== 32'd0) $display("FAIL reset_out_nop got %h want 0", bus0.out); else n_pass++;
    read0(hi, lo);
    n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
    read1(h16, l16);
    n_checks++; if ({h16, l16} !== 32'd0) $display("FAIL reset_hilo16 got %h want 0", {h16, l16}); else n_pass++;
  endtask

  // Shared table walker for 32-bit ops; comparisons are inline per entry.
  task automatic test_table(input string name, input logic [3:0] ops[], input logic [31:0] as[],
                            input logic [31:0] bs[], input logic hold_req);
    int unsigned cyc;
    logic [31:0] last, hi, lo, old_hi;
    exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      run0(ops[i], as[i], bs[i], hold_req, cyc, last, hi, lo, e, old_hi);
      n_checks++; if (cyc !== e.lat) $display("FAIL %s[%0d] busy_cycles got %0d want %0d", name, i, cyc, e.lat); else n_pass++;
      n_checks++; if (last !== old_hi) $display("FAIL %s[%0d] hi_during_completion got %h want %h", name, i, last, old_hi); else n_pass++;
      n_checks++; if (hi !== e.hilo[63:32]) $display("FAIL %s[%0d] hi got %h want %h", name, i, hi, e.hilo[63:32]); else n_pass++;
      n_checks++; if (lo !== e.hilo[31:0]) $display("FAIL %s[%0d] lo got %h want %h", name, i, lo, e.hilo[31:0]); else n_pass++;
    end
  endtask

  task automatic test_mult();
    logic [3:0]  ops[] = '{OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] as[]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, $urandom};
    logic [31:0] bs[]  = '{32'd3, 32'd3, $urandom};
    test_table("mult", ops, as, bs, 1'b0);
  endtask

  task automatic test_mac();
    logic [31:0] hi, lo;
    logic [3:0]  ops[] = '{OP_MADDU, OP_MSUB, OP_MADD, OP_MSUBU, OP_MADD};
    logic [31:0] as[]  = '{32'd1, 32'd2, $urandom, $urandom, 32'h80000000};
    logic [31:0] bs[]  = '{32'd1, 32'd1, $urandom, $urandom, 32'h80000000};
    mt0(OP_MTHI, 32'd1);
    mt0(OP_MTLO, 32'hFFFFFFFF);
    read0(hi, lo);
    n_checks++; if (hi !== m_hi) $display("FAIL mthi got %h want %h", hi, m_hi); else n_pass++;
    n_checks++; if (lo !== m_lo) $display("FAIL mtlo got %h want %h", lo, m_lo); else n_pass++;
    test_table("mac", ops, as, bs, 1'b0);
  endtask

  task automatic test_div();
    logic [3:0]  ops[] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as[]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9, 32'd7,
                           $urandom, $urandom};
    logic [31:0] bs[]  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE,
                           $urandom_range(1, 5000), $urandom};
    test_table("div", ops, as, bs, 1'b0);
  endtask

  task automatic test_req();
    logic [31:0] hi, lo;
    logic [3:0]  ops[] = '{OP_DIV};
    logic [31:0] as[]  = '{32'd1000};
    logic [31:0] bs[]  = '{32'hFFFFFFFD};
    bus0.req = 1'b1; bus0.start = 1'b1; bus0.op = OP_MULT; bus0.a = 32'd5; bus0.b = 32'd7;
    tick();
    bus0.start = 1'b0;
    n_checks++; if (bus0.busy !== 1'b0) $display("FAIL req_start busy got %b want 0", bus0.busy); else n_pass++;
    bus0.op = OP_MTHI; bus0.a = 32'h1234;
    tick();
    bus0.req = 1'b0; bus0.op = 4'd12;
    read0(hi, lo);
    n_checks++; if (hi !== m_hi) $display("FAIL req_block hi got %h want %h", hi, m_hi); else n_pass++;
    n_checks++; if (lo !== m_lo) $display("FAIL req_block lo got %h want %h", lo, m_lo); else n_pass++;
    test_table("req_mid_div", ops, as, bs, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    exp_t dropped;
    logic [3:0]  ops[] = '{OP_MULT};
    logic [31:0] as[]  = '{32'd12345};
    logic [31:0] bs[]  = '{32'hFFFFFF00};
    dropped.hilo = model32(OP_DIVU, 32'd99, 32'd4, m_hi, m_lo);
    dropped.lat  = 33;
    sb0.push_back(dropped);
    bus0.start = 1'b1; bus0.op = OP_DIVU; bus0.a = 32'd99; bus0.b = 32'd4;
    tick();
    bus0.start = 1'b0; bus0.op = 4'd12;
    for (int i = 0; i < 8; i++) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    void'(sb0.pop_front());
    m_hi = '0; m_lo = '0;
    n_checks++; if (bus0.busy !== 1'b0) $display("FAIL rst_mid busy got %b want 0", bus0.busy); else n_pass++;
    read0(hi, lo);
    n_checks++; if (hi !== 32'd0) $display("FAIL rst_mid hi got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'd0) $display("FAIL rst_mid lo got %h want 0", lo); else n_pass++;
    test_table("after_rst", ops, as, bs, 1'b0);
  endtask

  task automatic test_w16();
    logic [3:0]  ops[3] = '{OP_MULTU, OP_DIVU, OP_DIV};
    logic [15:0] as[3]  = '{16'hFFFF, 16'd100, 16'hFF9C};
    logic [15:0] bs[3]  = '{16'hFFFF, 16'd7, 16'd7};
    exp_t        tbl[3];
    exp_t        e;
    int unsigned cyc;
    logic [15:0] hi, lo;
    tbl[0].hilo = {32'd0, 16'hFFFE, 16'h0001}; tbl[0].lat = 1;
    tbl[1].hilo = {32'd0, 16'd2, 16'd14};      tbl[1].lat = 17;
    tbl[2].hilo = {32'd0, 16'hFFFE, 16'hFFF2}; tbl[2].lat = 17;
    for (int i = 0; i < 3; i++) begin
      sb1.push_back(tbl[i]);
      bus1.start = 1'b1; bus1.op = ops[i]; bus1.a = as[i]; bus1.b = bs[i];
      tick();
      bus1.start = 1'b0; bus1.op = 4'd12;
      cyc = 0;
      while (bus1.busy === 1'b1 && cyc < 100) begin
        cyc++;
        tick();
      end
      read1(hi, lo);
      e = sb1.pop_front();
      n_checks++; if (cyc !== e.lat) $display("FAIL w16[%0d] busy_cycles got %0d want %0d", i, cyc, e.lat); else n_pass++;
      n_checks++; if (hi !== e.hilo[31:16]) $display("FAIL w16[%0d] hi got %h want %h", i, hi, e.hilo[31:16]); else n_pass++;
      n_checks++; if (lo !== e.hilo[15:0]) $display("FAIL w16[%0d] lo got %h want %h", i, lo, e.hilo[15:0]); else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult();
    test_mac();
    test_div();
    test_req();
    test_reset_mid();
    test_w16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
